// File: rtl/rr_sel_arbiter_pkg.sv
// rtl/rr_sel_arbiter_pkg.sv - shared constants, state type and helpers for rr_sel_arbiter
//
// Package rr_sel_pkg:
//   SEL_A/SEL_B/SEL_C : mux select codes for sources a/b/c (2'b11 never produced)
//   SEL_W, N_REQ      : select width and requester count
//   MAX_HOLD_DEF      : default burst limit per grant when RR_SEL_LOCK_EN is defined
//   state_t           : arbiter FSM states
//   next_src()        : modulo-3 successor used by the round-robin search
package rr_sel_pkg;

  localparam int SEL_W        = 2;
  localparam int N_REQ        = 3;
  localparam int MAX_HOLD_DEF = 4;

  localparam logic [SEL_W-1:0] SEL_A = 2'b00;
  localparam logic [SEL_W-1:0] SEL_B = 2'b01;
  localparam logic [SEL_W-1:0] SEL_C = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Wraps 2 -> 0 so the 2-bit pointer can never reach the illegal code 3.
  function automatic logic [SEL_W-1:0] next_src(input logic [SEL_W-1:0] p);
    return (p >= SEL_C) ? SEL_A : p + 2'd1;
  endfunction

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// rtl/rr_sel_arbiter_if.sv - request/select handshake bundle between requesters, arbiter and mux
//
// Signals:
//   req       : per-source request (bit0=a, bit1=b, bit2=c)
//   out_ready : downstream accepts the current select
//   sel       : registered mux select (00/01/10 only)
//   grant     : registered one-hot grant matching sel, zero when not valid
//   out_valid : sel/grant valid this cycle
//   lock      : per-source grant extension request (only with RR_SEL_LOCK_EN)
// Modports: master = arbiter side, slave = requester/downstream side.
interface rr_sel_arbiter_if;
  import rr_sel_pkg::*;

  logic [N_REQ-1:0] req;
  logic             out_ready;
  logic [SEL_W-1:0] sel;
  logic [N_REQ-1:0] grant;
  logic             out_valid;
`ifdef RR_SEL_LOCK_EN
  logic [N_REQ-1:0] lock;

  modport master (input req, out_ready, lock, output sel, grant, out_valid);
  modport slave  (output req, out_ready, lock, input sel, grant, out_valid);
`else
  modport master (input req, out_ready, output sel, grant, out_valid);
  modport slave  (output req, out_ready, input sel, grant, out_valid);
`endif

endinterface

// File: rtl/rr_sel_arbiter_pick.sv
// rtl/rr_sel_arbiter_pick.sv - combinational round-robin winner search (module rr_pick)
//
// Ports:
//   req      : in  candidate requests
//   last_ptr : in  index of the most recently served source; search starts just after it
//   found    : out at least one request present
//   idx      : out winning source index (00/01/10)
//   onehot   : out one-hot form of idx, zero when nothing found
module rr_pick
  import rr_sel_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found  = 1'b0;
    idx    = SEL_A;
    onehot = '0;
    cand   = next_src(last_ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[cand]) begin
        found        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
      cand = next_src(cand);
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// rtl/rr_sel_arbiter.sv - round-robin 3:1 mux select arbiter with valid/ready handshake
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : rr_sel_arbiter_if.master (req, out_ready in; sel, grant, out_valid out;
//           lock in when built with RR_SEL_LOCK_EN)
// Optional feature macro: RR_SEL_LOCK_EN (grant extension up to MAX_HOLD beats).
import rr_sel_pkg::*;

module rr_sel_arbiter
`ifdef RR_SEL_LOCK_EN
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
)
`endif
(
  input logic             clk,
  input logic             reset,
  rr_sel_arbiter_if.master bus
);

  state_t           state;
  logic [SEL_W-1:0] last_ptr;
  logic [SEL_W-1:0] sel_q;
  logic [N_REQ-1:0] grant_q;
  logic             valid_q;

  logic             accept;
  logic             keep;
  logic [SEL_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick_req;
  logic             found;
  logic [SEL_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_oh;

  assign accept = valid_q && bus.out_ready;

  // In GRANT the search restarts from the source being accepted this cycle,
  // which is what last_ptr becomes at the same edge.
  assign pick_ptr = (state == GRANT) ? sel_q : last_ptr;

`ifdef RR_SEL_LOCK_EN
  logic [3:0] beat_cnt;
  logic       at_limit;

  assign keep     = bus.lock[sel_q] && (beat_cnt < 4'(MAX_HOLD - 1));
  assign at_limit = bus.lock[sel_q] && (beat_cnt == 4'(MAX_HOLD - 1));
  // A source that used its full burst sits out one arbitration.
  assign pick_req = (state == GRANT && at_limit) ? (bus.req & ~grant_q) : bus.req;
`else
  assign keep     = 1'b0;
  assign pick_req = bus.req;
`endif

  rr_pick u_pick (
    .req      (pick_req),
    .last_ptr (pick_ptr),
    .found    (found),
    .idx      (pick_idx),
    .onehot   (pick_oh)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_ptr <= SEL_C;
      sel_q    <= SEL_A;
      grant_q  <= '0;
      valid_q  <= 1'b0;
`ifdef RR_SEL_LOCK_EN
      beat_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel_q   <= pick_idx;
            grant_q <= pick_oh;
            valid_q <= 1'b1;
            state   <= GRANT;
`ifdef RR_SEL_LOCK_EN
            beat_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (accept) begin
            if (keep) begin
`ifdef RR_SEL_LOCK_EN
              beat_cnt <= beat_cnt + 4'd1;
`endif
            end else begin
              last_ptr <= sel_q;
`ifdef RR_SEL_LOCK_EN
              beat_cnt <= '0;
`endif
              if (found) begin
                sel_q   <= pick_idx;
                grant_q <= pick_oh;
              end else begin
                // sel keeps its last value so the mux input does not toggle.
                grant_q <= '0;
                valid_q <= 1'b0;
                state   <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb/tb_rr_sel_arbiter.sv - directed self-checking bench for rr_sel_arbiter
module tb_rr_sel_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  rr_sel_arbiter_if bus ();

  rr_sel_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] s, input logic [2:0] g, input logic v);
    chk({tag, ".sel"}, 32'(bus.sel), 32'(s));
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
  endtask

  // sel must never take the code the downstream mux has no input for
  always @(negedge clk) begin
    if (!reset) chk("sel_legal", 32'(bus.sel == 2'b11), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rr_exp [6];
    logic [1:0] lk_exp [6];
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    lk_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.req = 3'b000;
    bus.out_ready = 1'b0;
`ifdef RR_SEL_LOCK_EN
    bus.lock = 3'b000;
`endif
    tick();
    tick();
    chk_out("reset", 2'b00, 3'b000, 1'b0);

    // idle with no requests keeps reset outputs
    reset = 1'b0;
    tick();
    chk_out("idle_noreq", 2'b00, 3'b000, 1'b0);

    // round robin, all requesting, zero-bubble
    bus.req = 3'b111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out($sformatf("rr%0d", i), rr_exp[i], 3'b001 << rr_exp[i], 1'b1);
    end

    // asynchronous reset mid-grant
    reset = 1'b1;
    #1;
    chk_out("async_reset", 2'b00, 3'b000, 1'b0);
    tick();
    reset = 1'b0;
    bus.req = 3'b001;
    bus.out_ready = 1'b0;
    tick();
    chk_out("post_reset", 2'b00, 3'b001, 1'b1);
    bus.req = 3'b000;
    bus.out_ready = 1'b1;
    tick();
    chk_out("post_reset_idle", 2'b00, 3'b000, 1'b0);

    // skip gap: last served 0, req 101 -> 2 then 0
    bus.req = 3'b101;
    tick();
    chk_out("gap_c", 2'b10, 3'b100, 1'b1);
    tick();
    chk_out("gap_a", 2'b00, 3'b001, 1'b1);
    bus.req = 3'b000;
    tick();
    chk_out("gap_idle", 2'b00, 3'b000, 1'b0);

    // backpressure with request dropped mid-stall
    bus.req = 3'b010;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("stall%0d", i), 2'b01, 3'b010, 1'b1);
      if (i == 2) bus.req = 3'b000;
    end
    bus.out_ready = 1'b1;
    tick();
    chk_out("stall_done", 2'b01, 3'b000, 1'b0);

    // single source held continuously gets back-to-back beats
    bus.req = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("solo%0d", i), 2'b00, 3'b001, 1'b1);
    end
    bus.req = 3'b000;
    tick();
    chk_out("solo_idle", 2'b00, 3'b000, 1'b0);

    // idle return: single beat from source c, sel held afterwards
    bus.req = 3'b100;
    tick();
    chk_out("one_c", 2'b10, 3'b100, 1'b1);
    bus.req = 3'b000;
    tick();
    chk_out("one_c_idle", 2'b10, 3'b000, 1'b0);
    tick();
    chk_out("one_c_idle2", 2'b10, 3'b000, 1'b0);

`ifdef RR_SEL_LOCK_EN
    // lock: four beats to source 0, then forced rotation to source 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req = 3'b011;
    bus.lock = 3'b001;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out($sformatf("lock%0d", i), lk_exp[i], 3'b001 << lk_exp[i], 1'b1);
    end
    bus.req = 3'b000;
    bus.lock = 3'b000;
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
